siggen_multi: RTL
=================

Name: siggen_multi

Overview:
- Multi-channel, multi-mode successor to the single-accumulator sine generator.
- One shared phase accumulator (wider, with fractional bits) drives N_CH channels. Each channel has its own phase offset.
- Each channel outputs sine (internal ROM), square, triangle or sawtooth, then amplitude scaling with saturation. The block feeds the DAC/scope-output stage.
- Two-stage registered pipeline with an output valid flag.

Parameters:
A_WIDTH, 8, waveform phase/ROM address width (ROM depth 2^A_WIDTH); A_WIDTH <= D_WIDTH required
D_WIDTH, 8, sample width, unsigned offset-binary (midpoint 2^(D_WIDTH-1))
ACC_WIDTH, 16, phase accumulator width; phase = acc[ACC_WIDTH-1 -: A_WIDTH]; ACC_WIDTH >= A_WIDTH
N_CH, 2, number of output channels

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
en  input  1  accumulator advance enable
sync  input  1  phase re-align: accumulator forced to 0
incr  input  ACC_WIDTH  accumulator step per enabled cycle
phase_offset  input  N_CH*A_WIDTH  per-channel offset; channel k uses bits [k*A_WIDTH +: A_WIDTH]
mode  input  2  0 sine, 1 square, 2 triangle, 3 sawtooth (all channels)
amp  input  D_WIDTH  gain; 2^(D_WIDTH-1) = unity
dout  output  N_CH*D_WIDTH  channel k sample at [k*D_WIDTH +: D_WIDTH]
dout_valid  output  1  dout reflects an enabled accumulator phase

Behaviour:
- Reset (rst=1 at edge): acc=0, all pipeline registers=0, dout=0, dout_valid=0. Reset overrides sync and en.
- Accumulator, on each edge:
  - sync=1: acc<=0 (priority over en).
  - else en=1: acc<=acc+incr, modulo 2^ACC_WIDTH; wrap is silent.
  - else acc holds.
- Stage 1 (every edge, not gated by en):
  - p_k = acc_phase + phase_offset_k mod 2^A_WIDTH, using the pre-update acc.
  - Registers raw_k, amp, and v1<=en&~sync.
  - mode, phase_offset and amp are sampled together here, so any control change appears on dout exactly 2 edges later, coherent across channels.
- raw_k by mode:
  - sine: ROM[p] = round((2^(D-1)-1)*sin(2*pi*p/2^A)) + 2^(D-1). ROM is a synchronous-read internal table: ROM[0]=128, ROM[64]=255, ROM[192]=1 at default widths.
  - square: 2^D-1 if p[A-1]=0, else 0.
  - sawtooth: p left-aligned to D bits (low bits zero).
  - triangle: t = p[A-1] ? ~{p[A-2:0],0} : {p[A-2:0],0}, left-aligned to D bits. Default widths: p=64->128, p=128->255, p=255->1.
- Stage 2 (every edge):
  - s = raw - 2^(D-1) (signed).
  - y = 2^(D-1) + ((s*amp) >>> (D-1)); arithmetic shift (floor).
  - Saturate y to [0, 2^D-1]; dout_k<=y.
  - dout_valid<=v1.
  - Internal product width must be sufficient that no overflow occurs before saturation.
- Latency: acc value present at edge n appears on dout after edge n+1. dout_valid is en delayed 2 edges, and is 0 for a cycle where sync=1.
- en=0: acc holds; pipeline keeps running, so dout repeats the held phase and dout_valid falls 2 edges later.
- rst mid-run: next edge clears everything. Recovery proceeds exactly as from power-up.
- incr=0 with en=1: constant output, dout_valid=1.

Test Plan (defaults A=D=8, ACC=16, N_CH=2, mode=sine, amp=128, offsets 0/64):
- Reset then start: rst=1 for 2 edges, then en=1, incr=256 -> dout=0 and dout_valid=0 during reset. After the 2nd enabled edge: dout_valid=1, ch0=128, ch1=255. Next edge: ch0=ROM[1]=131, ch1=ROM[65].
- Wrap: incr=0x8000, mode=square, offsets 0/0 -> ch0 alternates 255,0,255,0 with dout_valid held 1. mode=sine -> 128 constant.
- Amplitude/saturation, square: amp=255 -> 255 / 0 (saturated both ends). amp=64 -> 191 / 64. amp=0 -> 128 constant.
- Triangle/sawtooth sweep: incr=256 over 256 cycles -> triangle peaks at 255 at p=128 and reaches 1 at p=255. Sawtooth ramps 0..255, then wraps to 0.
- sync with en=1 mid-sweep at acc=0x3700 -> acc=0 next edge; phase-0 sample on dout 2 edges later. dout_valid=0 for exactly the one sync cycle's slot.
- Mode change and rst mid-run:
  - mode sine->square at edge n -> dout changes at edge n+2, both channels simultaneously.
  - rst pulse for 1 cycle -> dout=0, dout_valid=0 next edge. Restart matches the first scenario.

Source files
------------

// File: rtl/siggen_multi_if.sv
// Control and sample bus between a waveform consumer and siggen_multi.
interface siggen_multi_if #(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned D_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned N_CH      = 2
);
    logic                    en;
    logic                    sync;
    logic [ACC_WIDTH-1:0]    incr;
    logic [N_CH*A_WIDTH-1:0] phase_offset;
    logic [1:0]              mode;
    logic [D_WIDTH-1:0]      amp;
    logic [N_CH*D_WIDTH-1:0] dout;
    logic                    dout_valid;

    modport master (output en, sync, incr, phase_offset, mode, amp,
                    input  dout, dout_valid);
    modport slave  (input  en, sync, incr, phase_offset, mode, amp,
                    output dout, dout_valid);
endinterface

// File: rtl/siggen_multi.sv
// Multi-channel waveform generator: one shared phase accumulator, per-channel
// phase offset, sine/square/triangle/sawtooth shaping and saturating gain.
module siggen_multi #(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned D_WIDTH   = 8,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned N_CH      = 2
) (
    input  logic          clk,
    input  logic          rst,
    siggen_multi_if.slave bus
);
    localparam int unsigned ROM_DEPTH = 1 << A_WIDTH;
    localparam int unsigned P_WIDTH   = 2 * D_WIDTH + 2;
    localparam int unsigned Y_WIDTH   = P_WIDTH + 1;
    localparam int unsigned EXT_WIDTH = P_WIDTH - D_WIDTH - 1;
    localparam logic [D_WIDTH-1:0] MID = {1'b1, {(D_WIDTH - 1){1'b0}}};
    localparam logic [1:0] MODE_SINE   = 2'd0;
    localparam logic [1:0] MODE_SQUARE = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_SAW    = 2'd3;
    localparam longint PI2_Q30 = 64'sd6746518852;

    // Rounded sine table entry, evaluated at elaboration in Q30 fixed point.
    function automatic logic [D_WIDTH-1:0] sine_entry(input int unsigned idx);
        longint n, i, m, x, term, sum, r;
        logic   neg;
        n   = longint'(ROM_DEPTH);
        i   = longint'(idx);
        neg = (i >= n / 2);
        if (neg) i = i - n / 2;
        m    = (i <= n / 4) ? i : n / 2 - i;
        x    = (m * PI2_Q30) / n;
        sum  = x;
        term = x;
        for (int k = 1; k <= 12; k++) begin
            term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        r = ((longint'(MID) - 64'sd1) * sum + (64'sd1 <<< 29)) >>> 30;
        return neg ? D_WIDTH'(longint'(MID) - r) : D_WIDTH'(longint'(MID) + r);
    endfunction

    logic [D_WIDTH-1:0] rom [ROM_DEPTH];
    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        assign rom[gi] = sine_entry(gi);
    end

    logic [ACC_WIDTH-1:0] acc;
    logic [A_WIDTH-1:0]   acc_phase;
    logic [D_WIDTH-1:0]   amp_q;
    logic                 v1;

    assign acc_phase = acc[ACC_WIDTH-1 -: A_WIDTH];

    // Shared accumulator; sync re-aligns all channels to phase zero.
    always_ff @(posedge clk) begin
        if (rst)           acc <= '0;
        else if (bus.sync) acc <= '0;
        else if (bus.en)   acc <= acc + bus.incr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            amp_q          <= '0;
            v1             <= 1'b0;
            bus.dout_valid <= 1'b0;
        end else begin
            amp_q          <= bus.amp;
            v1             <= bus.en & ~bus.sync;
            bus.dout_valid <= v1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [A_WIDTH-1:0]        p;
        logic [A_WIDTH-1:0]        tri_ph;
        logic [D_WIDTH-1:0]        raw_next;
        logic [D_WIDTH-1:0]        raw;
        logic [D_WIDTH:0]          s;
        logic signed [P_WIDTH-1:0] prod;
        logic signed [P_WIDTH-1:0] sh;
        logic [Y_WIDTH-1:0]        y;
        logic [D_WIDTH-1:0]        y_sat;
        logic [D_WIDTH-1:0]        dout_q;

        // Stage 1 shaping from the pre-update accumulator phase.
        always_comb begin
            p        = acc_phase + bus.phase_offset[k*A_WIDTH +: A_WIDTH];
            tri_ph   = p[A_WIDTH-1] ? ~{p[A_WIDTH-2:0], 1'b0} : {p[A_WIDTH-2:0], 1'b0};
            raw_next = '0;
            case (bus.mode)
                MODE_SINE:   raw_next = rom[p];
                MODE_SQUARE: raw_next = p[A_WIDTH-1] ? '0 : '1;
                MODE_TRI:    raw_next = D_WIDTH'(tri_ph) << (D_WIDTH - A_WIDTH);
                MODE_SAW:    raw_next = D_WIDTH'(p) << (D_WIDTH - A_WIDTH);
                default:     raw_next = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) raw <= '0;
            else     raw <= raw_next;
        end

        // Stage 2 gain: operands sign/zero-extended so the product cannot wrap.
        always_comb begin
            s     = {1'b0, raw} - {1'b0, MID};
            prod  = {{EXT_WIDTH{s[D_WIDTH]}}, s} * {{EXT_WIDTH{1'b0}}, 1'b0, amp_q};
            sh    = prod >>> (D_WIDTH - 1);
            y     = {sh[P_WIDTH-1], sh} + Y_WIDTH'(MID);
            y_sat = y[D_WIDTH-1:0];
            if (y[Y_WIDTH-1])                  y_sat = '0;
            else if (|y[Y_WIDTH-2:D_WIDTH])    y_sat = '1;
        end

        always_ff @(posedge clk) begin
            if (rst) dout_q <= '0;
            else     dout_q <= y_sat;
        end

        assign bus.dout[k*D_WIDTH +: D_WIDTH] = dout_q;
    end
endmodule
